// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-side control bundle for hazard_fwd_ctrl: ID fields and stall/flush in,
// forwarding selects and stall controls out.
interface hazard_fwd_ctrl_if #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
);
  logic             ext_stall;
  logic             flush;
  logic             id_valid;
  logic [RA_W-1:0]  id_rs, id_rt, id_rd;
  logic             id_use_rs, id_use_rt;
  logic             id_wr, id_ld, id_st;
  logic [1:0]       fwd_rs_sel, fwd_rt_sel;
  logic             mem_mem_fwd;
  logic             stall_if_id;
  logic             bubble_ex;
  logic [CNT_W-1:0] stall_count;

  modport slave (
    input  ext_stall, flush, id_valid, id_rs, id_rt, id_rd,
           id_use_rs, id_use_rt, id_wr, id_ld, id_st,
    output fwd_rs_sel, fwd_rt_sel, mem_mem_fwd, stall_if_id, bubble_ex, stall_count
  );

  modport master (
    output ext_stall, flush, id_valid, id_rs, id_rt, id_rd,
           id_use_rs, id_use_rt, id_wr, id_ld, id_st,
    input  fwd_rs_sel, fwd_rt_sel, mem_mem_fwd, stall_if_id, bubble_ex, stall_count
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding / hazard control: shadows EX, MEM, WB writer state and derives operand
// forwarding selects, MEM-to-MEM store forwarding, load-use stalls and a stall counter.
module hazard_fwd_ctrl #(
  parameter int RA_W     = 4,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  hazard_fwd_ctrl_if.slave  bus
);
  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] rs, rt, rd;
    logic            use_rs, use_rt, wr, ld, st;
  } slot_t;

  slot_t            r_ex, r_mem, r_wb;
  logic             r_flush_pend;
  logic [CNT_W-1:0] r_cnt;

  slot_t w_id;
  logic  w_load_use, w_kill, w_bubble;

  function automatic logic f_match(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
    return (a == b) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic f_writes(input slot_t s, input logic [RA_W-1:0] r);
    return s.v && s.wr && f_match(s.rd, r);
  endfunction

  // MEM is the younger producer and wins; a load still in MEM has no data yet.
  function automatic logic [1:0] f_sel(input logic use_r, input logic [RA_W-1:0] r);
    if (!(r_ex.v && use_r))                 return 2'b00;
    else if (f_writes(r_mem, r) && !r_mem.ld) return 2'b01;
    else if (f_writes(r_wb, r))             return 2'b10;
    else                                    return 2'b00;
  endfunction

  // Store data on rt is not a stall source; it is patched by mem_mem_fwd instead.
  assign w_load_use = bus.id_valid && r_ex.v && r_ex.ld && r_ex.wr &&
                      ((bus.id_use_rs && f_match(bus.id_rs, r_ex.rd)) ||
                       (bus.id_use_rt && f_match(bus.id_rt, r_ex.rd) && !bus.id_st));
  assign w_kill     = bus.flush || r_flush_pend;
  assign w_bubble   = w_load_use && !bus.ext_stall;

  always_comb begin
    w_id        = '0;
    w_id.v      = bus.id_valid && !w_load_use && !w_kill;
    w_id.rs     = bus.id_rs;
    w_id.rt     = bus.id_rt;
    w_id.rd     = bus.id_rd;
    w_id.use_rs = bus.id_use_rs;
    w_id.use_rt = bus.id_use_rt;
    w_id.wr     = bus.id_wr;
    w_id.ld     = bus.id_ld;
    w_id.st     = bus.id_st;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex         <= '0;
      r_mem        <= '0;
      r_wb         <= '0;
      r_flush_pend <= 1'b0;
    end else if (!bus.ext_stall) begin
      r_wb         <= r_mem;
      r_mem        <= r_ex;
      r_ex         <= w_id;
      r_flush_pend <= 1'b0;
    end else begin
      // A flush seen while memory holds the pipe must still kill the ID instruction.
      r_flush_pend <= r_flush_pend || bus.flush;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (w_bubble && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign bus.fwd_rs_sel  = f_sel(r_ex.use_rs, r_ex.rs);
  assign bus.fwd_rt_sel  = f_sel(r_ex.use_rt, r_ex.rt);
  assign bus.mem_mem_fwd = r_mem.v && r_mem.st && r_wb.v && r_wb.ld && r_wb.wr &&
                           f_match(r_mem.rt, r_wb.rd);
  assign bus.stall_if_id = w_load_use || bus.ext_stall;
  assign bus.bubble_ex   = w_bubble;
  assign bus.stall_count = r_cnt;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: hand-derived expected outputs are queued per driven
// cycle and compared at the following falling edge.
module tb_hazard_fwd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_fwd_ctrl_if #(.RA_W(4), .CNT_W(4)) ifa ();
  hazard_fwd_ctrl_if #(.RA_W(4), .CNT_W(4)) ifz ();

  hazard_fwd_ctrl #(.RA_W(4), .ZERO_REG(1), .CNT_W(4)) dut  (.clk(clk), .rst(rst), .bus(ifa));
  hazard_fwd_ctrl #(.RA_W(4), .ZERO_REG(0), .CNT_W(4)) dut0 (.clk(clk), .rst(rst), .bus(ifz));

  assign ifz.ext_stall = ifa.ext_stall;
  assign ifz.flush     = ifa.flush;
  assign ifz.id_valid  = ifa.id_valid;
  assign ifz.id_rs     = ifa.id_rs;
  assign ifz.id_rt     = ifa.id_rt;
  assign ifz.id_rd     = ifa.id_rd;
  assign ifz.id_use_rs = ifa.id_use_rs;
  assign ifz.id_use_rt = ifa.id_use_rt;
  assign ifz.id_wr     = ifa.id_wr;
  assign ifz.id_ld     = ifa.id_ld;
  assign ifz.id_st     = ifa.id_st;

  typedef struct packed {
    logic v; logic [3:0] rs, rt, rd; logic urs, urt, wr, ld, st;
  } ins_t;

  typedef struct {
    string tag; logic [1:0] rs, rt, zrs; logic mmf, st, bu; logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;
  logic [3:0] ecnt = 4'd0;
  localparam ins_t NOP = '0;

  function automatic ins_t alu(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
    return '{v:1'b1, rs:rs, rt:rt, rd:rd, urs:1'b1, urt:1'b1, wr:1'b1, ld:1'b0, st:1'b0};
  endfunction
  function automatic ins_t ldi(input logic [3:0] rd, input logic [3:0] rs);
    return '{v:1'b1, rs:rs, rt:4'd0, rd:rd, urs:1'b1, urt:1'b0, wr:1'b1, ld:1'b1, st:1'b0};
  endfunction
  function automatic ins_t sti(input logic [3:0] rs, input logic [3:0] rt);
    return '{v:1'b1, rs:rs, rt:rt, rd:4'd0, urs:1'b1, urt:1'b1, wr:1'b0, ld:1'b0, st:1'b1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input ins_t i, input logic fl, input logic es);
    ifa.id_valid  = i.v;   ifa.id_rs = i.rs; ifa.id_rt = i.rt; ifa.id_rd = i.rd;
    ifa.id_use_rs = i.urs; ifa.id_use_rt = i.urt;
    ifa.id_wr = i.wr; ifa.id_ld = i.ld; ifa.id_st = i.st;
    ifa.flush = fl;   ifa.ext_stall = es;
  endtask

  task automatic cyc(input string tag, input ins_t i, input logic fl, input logic es,
                     input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] zrs,
                     input logic mmf, input logic st, input logic bu);
    exp_t e;
    @(posedge clk); #1;
    drive(i, fl, es);
    e = '{tag:tag, rs:rs, rt:rt, zrs:zrs, mmf:mmf, st:st, bu:bu, cnt:ecnt};
    q.push_back(e);
  endtask

  task automatic cn(input string tag, input ins_t i, input logic [1:0] rs, input logic [1:0] rt,
                    input logic mmf, input logic st, input logic bu);
    cyc(tag, i, 1'b0, 1'b0, rs, rt, rs, mmf, st, bu);
  endtask

  task automatic bump();
    ecnt = (ecnt == 4'hF) ? 4'hF : ecnt + 4'd1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rs"},  ifa.fwd_rs_sel, 0);
    chk({tag, ".rt"},  ifa.fwd_rt_sel, 0);
    chk({tag, ".mmf"}, ifa.mem_mem_fwd, 0);
    chk({tag, ".st"},  ifa.stall_if_id, 0);
    chk({tag, ".bu"},  ifa.bubble_ex, 0);
    chk({tag, ".cnt"}, ifa.stall_count, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".rs"},   ifa.fwd_rs_sel, e.rs);
      chk({e.tag, ".rt"},   ifa.fwd_rt_sel, e.rt);
      chk({e.tag, ".mmf"},  ifa.mem_mem_fwd, e.mmf);
      chk({e.tag, ".st"},   ifa.stall_if_id, e.st);
      chk({e.tag, ".bu"},   ifa.bubble_ex, e.bu);
      chk({e.tag, ".cnt"},  ifa.stall_count, e.cnt);
      chk({e.tag, ".zrs"},  ifz.fwd_rs_sel, e.zrs);
      chk({e.tag, ".zst"},  ifz.stall_if_id, e.st);
    end
  end

  initial begin
    drive(NOP, 1'b0, 1'b0);
    #2 chk_zero("reset");
    @(negedge clk); rst = 1'b0;

    // EX/MEM forwarding, then MEM/WB forwarding with one NOP in between
    cn("add",     alu(3, 1, 2), 0, 0, 0, 0, 0);
    cn("sub",     alu(4, 3, 5), 0, 0, 0, 0, 0);
    cn("fwdMem",  NOP,          1, 0, 0, 0, 0);
    cn("idle0",   NOP,          0, 0, 0, 0, 0);
    cn("add2",    alu(3, 1, 2), 0, 0, 0, 0, 0);
    cn("nop2",    NOP,          0, 0, 0, 0, 0);
    cn("sub2",    alu(4, 3, 5), 0, 0, 0, 0, 0);
    cn("fwdWb",   NOP,          2, 0, 0, 0, 0);
    cn("idle1",   NOP,          0, 0, 0, 0, 0);

    // load-use: one bubble, then both operands from MEM/WB
    cn("ld6",     ldi(6, 1),    0, 0, 0, 0, 0);
    cn("luStall", alu(7, 6, 6), 0, 0, 0, 1, 1); bump();
    cn("luHold",  alu(7, 6, 6), 0, 0, 0, 0, 0);
    cn("luFwd",   NOP,          2, 2, 0, 0, 0);

    // load then store of the loaded register: no stall, MEM-to-MEM forward
    cn("ld2",     ldi(2, 1),    0, 0, 0, 0, 0);
    cn("st2",     sti(9, 2),    0, 0, 0, 0, 0);
    cn("stEx",    NOP,          0, 0, 0, 0, 0);
    cn("mmf",     NOP,          0, 0, 1, 0, 0);
    cn("idle2",   NOP,          0, 0, 0, 0, 0);

    // r0 writer/reader: no match with hardwired zero, match otherwise
    cn("wr0",     alu(0, 1, 2), 0, 0, 0, 0, 0);
    cn("rd0",     alu(4, 0, 5), 0, 0, 0, 0, 0);
    cyc("zero",   NOP, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0);
    cn("idle3",   NOP,          0, 0, 0, 0, 0);

    // memory stall for 3 cycles with a flush in the middle one
    cn("addX",    alu(3, 1, 2), 0, 0, 0, 0, 0);
    cn("subX",    alu(4, 3, 5), 0, 0, 0, 0, 0);
    cyc("es1",    alu(8, 3, 3), 1'b0, 1'b1, 1, 0, 1, 0, 1, 0);
    cyc("es2",    alu(8, 3, 3), 1'b1, 1'b1, 1, 0, 1, 0, 1, 0);
    cyc("es3",    alu(8, 3, 3), 1'b0, 1'b1, 1, 0, 1, 0, 1, 0);
    cn("esRel",   alu(8, 3, 3), 1, 0, 0, 0, 0);
    cn("killed",  alu(10, 4, 1), 0, 0, 0, 0, 0);
    cn("after",   NOP,          2, 0, 0, 0, 0);
    cn("idle4",   NOP,          0, 0, 0, 0, 0);

    // drive the 4-bit counter into saturation
    for (int k = 0; k < 15; k++) begin
      cn("satA", ldi(6, 1),    0, 0, 0, 0, 0);
      cn("satB", alu(7, 6, 6), 0, 0, 0, 1, 1); bump();
      cn("satC", alu(7, 6, 6), 0, 0, 0, 0, 0);
      cn("satD", NOP,          2, 2, 0, 0, 0);
    end
    cn("lastA", ldi(6, 1), 0, 0, 0, 0, 0);

    // reset in the middle of a load-use stall acts without a clock edge
    @(posedge clk); #1;
    drive(alu(7, 6, 6), 1'b0, 1'b0);
    #2;
    chk("midStall.st",  ifa.stall_if_id, 1);
    chk("midStall.cnt", ifa.stall_count, 15);
    rst = 1'b1;
    #1 chk_zero("asyncRst");
    @(posedge clk); #1;
    drive(NOP, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;
    ecnt = 4'd0;

    cn("pAdd", alu(3, 1, 2), 0, 0, 0, 0, 0);
    cn("pSub", alu(4, 3, 5), 0, 0, 0, 0, 0);
    cn("pFwd", NOP,          1, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("queueDrained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
